// File: rtl/w_update_bank.sv
// w_update_bank: two-stage weight update bank for an adaptive filter.
// Stage 1 scales taps by mu_error, stage 2 accumulates into weights.
module w_update_bank #(
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int TAPS      = 4,
  parameter int RESET_VAL = 0,
  parameter int SAT_EN    = 1,
  localparam int LIW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        mu_error,
  input  logic [TAPS*WIDTH-1:0]   x_vec,
  input  logic                    freeze,
  input  logic                    load,
  input  logic [LIW-1:0]          load_idx,
  input  logic [WIDTH-1:0]        load_val,
  output logic [TAPS*WIDTH-1:0]   weights,
  output logic                    upd_valid,
  output logic [15:0]             upd_cnt
);

  localparam int PW = 2 * WIDTH + 1;

  localparam logic [WIDTH-1:0] MAXW =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINW =
    {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic signed [PW-1:0] MAXP =
    {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINP =
    {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  localparam logic signed [PW-1:0] RND =
    {{(PW-1){1'b0}}, 1'b1} << (QP - 1);

  localparam longint RV = longint'(RESET_VAL) <<< QP;
  localparam logic [WIDTH-1:0] RST_W = RV[WIDTH-1:0];

  // Rounded Q-format product, clamped or truncated to WIDTH.
  function automatic logic [WIDTH-1:0] scale(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] m
  );
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] me;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    logic [WIDTH-1:0] wv;
    logic [WIDTH-1:0] sv;
    xe = PW'(x);
    me = PW'(m);
    p  = xe * me + RND;
    r  = p >>> QP;
    wv = r[WIDTH-1:0];
    if (r > MAXP)
      sv = MAXW;
    else if (r < MINP)
      sv = MINW;
    else
      sv = wv;
    return (SAT_EN != 0) ? sv : wv;
  endfunction

  // Weight plus increment with one guard bit.
  function automatic logic [WIDTH-1:0] accum(
    input logic [WIDTH-1:0] w,
    input logic [WIDTH-1:0] inc
  );
    logic [WIDTH:0] s;
    logic [WIDTH-1:0] sv;
    s = {w[WIDTH-1], w} + {inc[WIDTH-1], inc};
    if (s[WIDTH] != s[WIDTH-1])
      sv = s[WIDTH] ? MINW : MAXW;
    else
      sv = s[WIDTH-1:0];
    return (SAT_EN != 0) ? sv : s[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] inc_d [TAPS];
  logic [WIDTH-1:0] inc_q [TAPS];
  logic [WIDTH-1:0] w_q   [TAPS];
  logic             p_valid;
  logic             commit;

  // Per-tap scaled increment for the current inputs.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      inc_d[k] = scale(x_vec[k*WIDTH +: WIDTH], mu_error);
    end
  end

  // Stage 1 register: increments and their valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        inc_q[k] <= '0;
      end
    end else begin
      p_valid <= in_valid;
      for (int k = 0; k < TAPS; k++) begin
        inc_q[k] <= inc_d[k];
      end
    end
  end

  // A pending increment under freeze is dropped, not held.
  assign commit = p_valid & ~freeze;

  // Stage 2: load beats commit on the addressed tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        w_q[k] <= RST_W;
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (load && (load_idx == LIW'(k)))
          w_q[k] <= load_val;
        else if (commit)
          w_q[k] <= accum(w_q[k], inc_q[k]);
      end
    end
  end

  // Commit pulse and saturating commit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid <= 1'b0;
      upd_cnt   <= '0;
    end else begin
      upd_valid <= commit;
      if (commit && (upd_cnt != 16'hFFFF))
        upd_cnt <= upd_cnt + 16'd1;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_out
    assign weights[k*WIDTH +: WIDTH] = w_q[k];
  end

endmodule

// File: tb/tb_w_update_bank.sv
// tb_w_update_bank: directed table, corner sequences and random
// stimulus against an integer reference model, SAT and wrap builds.
module tb_w_update_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] mu_error;
  logic [63:0] x_vec;
  logic        freeze;
  logic        load;
  logic [1:0]  load_idx;
  logic [15:0] load_val;
  logic [63:0] ws;
  logic [63:0] ww;
  logic        upd_s;
  logic        upd_w;
  logic [15:0] cnt_s;
  logic [15:0] cnt_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  w_update_bank #(.SAT_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .mu_error(mu_error), .x_vec(x_vec), .freeze(freeze),
    .load(load), .load_idx(load_idx), .load_val(load_val),
    .weights(ws), .upd_valid(upd_s), .upd_cnt(cnt_s)
  );

  w_update_bank #(.SAT_EN(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .mu_error(mu_error), .x_vec(x_vec), .freeze(freeze),
    .load(load), .load_idx(load_idx), .load_val(load_val),
    .weights(ww), .upd_valid(upd_w), .upd_cnt(cnt_w)
  );

  // reference model state: index 0 saturating, 1 wrapping
  int mw   [2][4];
  int pinc [2][4];
  bit pv   = 0;
  bit mupd = 0;
  int mcnt = 0;

  function automatic int sx16(longint v);
    logic [15:0] t;
    t = v[15:0];
    return int'(signed'(t));
  endfunction

  function automatic int fit(longint v, bit sat);
    if (!sat) return sx16(v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int inc_of(int x, int mu, bit sat);
    longint p;
    p = longint'(x) * longint'(mu) + 2048;
    return fit(p >>> 12, sat);
  endfunction

  task automatic model_edge();
    bit commit;
    if (reset) begin
      pv = 0; mupd = 0; mcnt = 0;
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < 4; k++) begin
          mw[m][k] = 0; pinc[m][k] = 0;
        end
    end else begin
      commit = pv && !freeze;
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < 4; k++) begin
          if (load && int'(load_idx) == k)
            mw[m][k] = sx16(longint'(load_val));
          else if (commit)
            mw[m][k] = fit(longint'(mw[m][k]) + pinc[m][k], m == 0);
        end
      mupd = commit;
      if (commit && mcnt < 65535) mcnt++;
      pv = in_valid;
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < 4; k++)
          pinc[m][k] = inc_of(sx16(longint'(x_vec[k*16 +: 16])),
                              sx16(longint'(mu_error)), m == 0);
    end
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk("model_w_sat", ws[k*16 +: 16], 16'(mw[0][k]));
      chk("model_w_wrap", ww[k*16 +: 16], 16'(mw[1][k]));
    end
    chk("model_upd_sat", {15'b0, upd_s}, {15'b0, mupd});
    chk("model_upd_wrap", {15'b0, upd_w}, {15'b0, mupd});
    chk("model_cnt_sat", cnt_s, 16'(mcnt));
    chk("model_cnt_wrap", cnt_w, 16'(mcnt));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    in_valid = 0; freeze = 0; load = 0;
  endtask

  typedef struct {
    logic [15:0] mu;
    logic [15:0] x0;
    logic [15:0] init;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
  } vec_t;

  vec_t tab [7];

  initial begin
    tab[0] = '{16'h0800, 16'h1000, 16'h0000, 16'h0800, 16'h0800};
    tab[1] = '{16'h0001, 16'h0800, 16'h0000, 16'h0001, 16'h0001};
    tab[2] = '{16'h0001, 16'h07FF, 16'h0000, 16'h0000, 16'h0000};
    tab[3] = '{16'h0800, 16'h1000, 16'h7F00, 16'h7FFF, 16'h8700};
    tab[4] = '{16'h0800, 16'hF000, 16'h8100, 16'h8000, 16'h7900};
    tab[5] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'hFFF0};
    tab[6] = '{16'hFFFF, 16'h0801, 16'h0000, 16'hFFFF, 16'hFFFF};

    reset = 1; idle();
    mu_error = 0; x_vec = 0; load_idx = 0; load_val = 0;
    cycle(); cycle();
    chk("reset_cnt", cnt_s, 16'h0000);
    chk("reset_w0", ws[15:0], 16'h0000);

    // directed table: load tap 0, one update, compare tap 0
    for (int i = 0; i < 7; i++) begin
      reset = 1; idle(); cycle();
      reset = 0;
      load = 1; load_idx = 0; load_val = tab[i].init;
      cycle();
      load = 0;
      in_valid = 1; mu_error = tab[i].mu;
      x_vec = {48'h0, tab[i].x0};
      cycle();
      in_valid = 0;
      cycle();
      chk("tab_sat", ws[15:0], tab[i].exp_sat);
      chk("tab_wrap", ww[15:0], tab[i].exp_wrap);
    end

    // basic update and its latency
    reset = 1; idle(); cycle();
    reset = 0;
    mu_error = 16'h0800; x_vec = {4{16'h1000}};
    in_valid = 1;
    cycle();
    in_valid = 0;
    chk("lat_upd_early", {15'b0, upd_s}, 16'h0000);
    chk("lat_w_early", ws[15:0], 16'h0000);
    cycle();
    for (int k = 0; k < 4; k++)
      chk("basic_w", ws[k*16 +: 16], 16'h0800);
    chk("basic_upd", {15'b0, upd_s}, 16'h0001);
    chk("basic_cnt", cnt_s, 16'h0001);
    cycle();
    chk("basic_upd_pulse", {15'b0, upd_s}, 16'h0000);

    // load and commit on the same tap: load wins
    in_valid = 1;
    cycle();
    in_valid = 0;
    load = 1; load_idx = 2; load_val = 16'h0123;
    cycle();
    load = 0;
    chk("coll_w0", ws[15:0], 16'h1000);
    chk("coll_w2", ws[47:32], 16'h0123);
    chk("coll_w3", ws[63:48], 16'h1000);
    chk("coll_upd", {15'b0, upd_s}, 16'h0001);
    chk("coll_cnt", cnt_s, 16'h0002);

    // frozen updates are discarded
    freeze = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("frz_upd", {15'b0, upd_s}, 16'h0000);
    end
    in_valid = 0;
    cycle();
    chk("frz_upd_tail", {15'b0, upd_s}, 16'h0000);
    freeze = 0;
    cycle();
    chk("frz_upd_after", {15'b0, upd_s}, 16'h0000);
    chk("frz_w0", ws[15:0], 16'h1000);
    chk("frz_w2", ws[47:32], 16'h0123);
    chk("frz_cnt", cnt_s, 16'h0002);

    // reset in the middle of a stream
    in_valid = 1;
    repeat (3) cycle();
    reset = 1;
    cycle();
    chk("rst_w0", ws[15:0], 16'h0000);
    chk("rst_cnt", cnt_s, 16'h0000);
    chk("rst_upd", {15'b0, upd_s}, 16'h0000);
    reset = 0;
    cycle();
    chk("rst_no_commit", {15'b0, upd_s}, 16'h0000);
    chk("rst_w0_hold", ws[15:0], 16'h0000);
    cycle();
    chk("rst_first_commit", {15'b0, upd_s}, 16'h0001);
    chk("rst_first_cnt", cnt_s, 16'h0001);
    chk("rst_first_w0", ws[15:0], 16'h0800);
    in_valid = 0;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      freeze   = ($urandom_range(0, 7) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_idx = 2'($urandom);
      load_val = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        mu_error = 16'($urandom_range(0, 2047)) - 16'd1024;
      else
        mu_error = 16'($urandom);
      x_vec = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w_update_bank.md
W_UPDATE_BANK -- requirements
Module: w_update_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16: word width of all data ports and weights, two's complement.
REQ-002 SHALL have parameter QP, default 12: fractional bits of all Q-format values.
REQ-003 SHALL have parameter TAPS, default 4: number of weight channels, range 1..64.
REQ-004 SHALL have parameter RESET_VAL, default 0: integer reset value of every weight.
REQ-005 SHALL have parameter SAT_EN, default 1: 1 = saturating arithmetic, 0 = wrap-around.
REQ-006 SHALL have clk  input  1: rising-edge clock.
REQ-007 SHALL have reset  input  1: synchronous, active-high.
REQ-008 SHALL have in_valid  input  1: mu_error and x_vec valid this cycle.
REQ-009 SHALL have mu_error  input  WIDTH: step-size-scaled error, shared by all taps.
REQ-010 SHALL have x_vec  input  TAPS*WIDTH: tap inputs, tap k at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have freeze  input  1: blocks weight commits.
REQ-012 SHALL have load  input  1: direct weight write strobe.
REQ-013 SHALL have load_idx  input  clog2(TAPS), minimum 1: tap index for load.
REQ-014 SHALL have load_val  input  WIDTH: value written on load.
REQ-015 SHALL have weights  output  TAPS*WIDTH: registered weights, same packing as x_vec.
REQ-016 SHALL have upd_valid  output  1: one-cycle pulse marking a completed update commit.
REQ-017 SHALL have upd_cnt  output  16: count of committed updates.

Function
REQ-018 Stage 1 SHALL form, per tap, the 2*WIDTH signed product x_k*mu_error.
REQ-019 Stage 1 SHALL add 2^(QP-1) to each product and select bits [QP +: WIDTH].
- SAT_EN=1: the shifted value is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- SAT_EN=0: the upper bits are truncated.
REQ-020 Stage 1 SHALL register all TAPS increments, plus a valid bit p_valid = in_valid, on every clock edge.
REQ-021 Stage 2 SHALL compute w_k + inc_k at WIDTH+1 bits and register it into w_k when p_valid=1 and freeze=0.
- SAT_EN=1: the sum saturates to the WIDTH range.
- SAT_EN=0: the sum wraps.
REQ-022 Latency: inputs sampled at edge N SHALL be reflected in weights after edge N+1. upd_valid SHALL be high for the cycle following edge N+1.
REQ-023 Back-to-back in_valid SHALL be accepted every cycle with no stalls and no lost updates.
REQ-024 While freeze=1, stage-2 commits SHALL be suppressed and the pending p_valid increment SHALL be discarded, not held. Stage 1 continues to register.
REQ-025 Load SHALL write load_val into tap load_idx at the next edge, regardless of freeze and p_valid.
REQ-026 If a load and a commit hit the same tap in the same cycle, the load SHALL win and that tap's increment SHALL be dropped. Other taps commit normally, and upd_valid still pulses.
REQ-027 A load_idx >= TAPS SHALL be ignored.
REQ-028 upd_cnt SHALL increment by 1 per committed update, i.e. each upd_valid pulse, and saturate at 0xFFFF.
REQ-029 upd_valid SHALL NOT pulse for suppressed (frozen) updates or for loads.

Reset
REQ-030 On reset, every w_k SHALL be set to (RESET_VAL <<< QP) truncated to WIDTH bits.
REQ-031 On reset, p_valid, all stage-1 increments, upd_valid and upd_cnt SHALL be set to 0.
REQ-032 Reset SHALL take priority over load, freeze and in_valid.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight increment, with no commit on the first edge after reset deassertion.

Verification
REQ-034 Basic update: TAPS=4, SAT_EN=1, mu_error=0x0800, x_vec all 0x1000, one in_valid pulse at edge N -> all weights 0x0800 after edge N+1; upd_valid one cycle; upd_cnt=1.
REQ-035 Rounding: mu_error=0x0001, x_0=0x0800, x_1=0x07FF -> w_0 += 1, w_1 += 0.
REQ-036 Saturation: load w_0=0x7F00, then mu_error=0x0800, x_0=0x1000 -> w_0=0x7FFF with SAT_EN=1, 0x8700 with SAT_EN=0. Negative case: w_0=0x8100, x_0=0xF000 -> 0x8000 with SAT_EN=1.
REQ-037 Collision and freeze: load tap 2 with 0x0123 in the same cycle as a commit -> w_2=0x0123 and other taps updated. Then freeze=1 during 3 consecutive in_valid cycles -> weights unchanged, no upd_valid, upd_cnt unchanged.
REQ-038 Reset mid-stream: continuous in_valid, reset for 1 cycle -> weights = RESET_VAL<<<QP, upd_cnt=0, and the first commit occurs 2 edges after the first post-reset in_valid.
